// File: rtl/flash_pkg.sv
// Shared definitions for the flash operation arbiter: op codes, field widths and FSM states.
package flash_pkg;

    localparam int ADDR_W = 24;
    localparam int NUM_W  = 9;
    localparam int DATA_W = 8;
    localparam int TYPE_W = 2;

    localparam logic [TYPE_W-1:0] OP_ERASE = 2'd0;
    localparam logic [TYPE_W-1:0] OP_WRITE = 2'd1;
    localparam logic [TYPE_W-1:0] OP_READ  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } arb_state_e;

    // Ops with no write stream start with the write phase already complete.
    function automatic logic wr_preset(input logic [TYPE_W-1:0] op_type);
        return op_type != OP_WRITE;
    endfunction

    // Ops with no read stream start with the read phase already complete.
    function automatic logic rd_preset(input logic [TYPE_W-1:0] op_type);
        return op_type != OP_READ;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int  cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = PTR_W'(cand);
                found       = 1'b1;
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/flash_op_arbiter.sv
// Round-robin arbiter sharing one flash_drive user port among P_REQ_NUM requesters,
// holding the grant through each op's data phase with a watchdog abort.
module flash_op_arbiter
    import flash_pkg::*;
#(
    parameter int P_REQ_NUM = 2,
    parameter int P_TIMEOUT = 2000000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [TYPE_W*P_REQ_NUM-1:0]   i_req_op_type,
    input  logic [ADDR_W*P_REQ_NUM-1:0]   i_req_op_addr,
    input  logic [NUM_W*P_REQ_NUM-1:0]    i_req_op_num,
    input  logic [P_REQ_NUM-1:0]          i_req_op_valid,
    output logic [P_REQ_NUM-1:0]          o_req_op_ready,
    input  logic [DATA_W*P_REQ_NUM-1:0]   i_req_write_data,
    input  logic [P_REQ_NUM-1:0]          i_req_write_sop,
    input  logic [P_REQ_NUM-1:0]          i_req_write_eop,
    input  logic [P_REQ_NUM-1:0]          i_req_write_valid,
    output logic [DATA_W-1:0]             o_req_read_data,
    output logic                          o_req_read_sop,
    output logic                          o_req_read_eop,
    output logic [P_REQ_NUM-1:0]          o_req_read_valid,
    output logic [P_REQ_NUM-1:0]          o_req_timeout,
    output logic [TYPE_W-1:0]             o_drv_op_type,
    output logic [ADDR_W-1:0]             o_drv_op_addr,
    output logic [NUM_W-1:0]              o_drv_op_num,
    output logic                          o_drv_op_valid,
    input  logic                          i_drv_op_ready,
    output logic [DATA_W-1:0]             o_drv_write_data,
    output logic                          o_drv_write_sop,
    output logic                          o_drv_write_eop,
    output logic                          o_drv_write_valid,
    input  logic [DATA_W-1:0]             i_drv_read_data,
    input  logic                          i_drv_read_sop,
    input  logic                          i_drv_read_eop,
    input  logic                          i_drv_read_valid
);

    localparam int PTR_W  = $clog2(P_REQ_NUM);
    localparam int WDOG_W = $clog2(P_TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(P_TIMEOUT - 1);

    arb_state_e           state;
    arb_state_e           state_nxt;
    logic [P_REQ_NUM-1:0] grant;
    logic [P_REQ_NUM-1:0] arb_grant;
    logic                 arb_any;
    logic [PTR_W-1:0]     arb_idx;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_ptr_nxt;
    logic [WDOG_W-1:0]    wdog;
    logic                 busy_seen;
    logic                 wr_done;
    logic                 rd_done;
    logic                 issue_ack;
    logic                 run_done;
    logic                 wdog_fire;
    logic                 wr_fwd_eop;

    rr_arbiter #(
        .N     (P_REQ_NUM),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (i_req_op_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign rr_ptr_nxt = (int'(grant_idx) == P_REQ_NUM - 1) ? '0 : grant_idx + PTR_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A normal completion takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        issue_ack = 1'b0;
        run_done  = 1'b0;
        wdog_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_drv_op_ready) begin
                    issue_ack = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (busy_seen && i_drv_op_ready && wr_done && rd_done) begin
                    run_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wdog == WDOG_LAST) begin
                    wdog_fire = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_req_op_ready = issue_ack ? grant : '0;
    assign o_req_timeout  = wdog_fire ? grant : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant          <= '0;
            grant_idx      <= '0;
            rr_ptr         <= '0;
            o_drv_op_type  <= '0;
            o_drv_op_addr  <= '0;
            o_drv_op_num   <= '0;
            o_drv_op_valid <= 1'b0;
            wdog           <= '0;
            busy_seen      <= 1'b0;
            wr_done        <= 1'b0;
            rd_done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant          <= arb_grant;
                        grant_idx      <= arb_idx;
                        o_drv_op_type  <= i_req_op_type[int'(arb_idx)*TYPE_W +: TYPE_W];
                        o_drv_op_addr  <= i_req_op_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                        o_drv_op_num   <= i_req_op_num[int'(arb_idx)*NUM_W +: NUM_W];
                        o_drv_op_valid <= 1'b1;
                        wdog           <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ack) begin
                        o_drv_op_valid <= 1'b0;
                        busy_seen      <= 1'b0;
                        wr_done        <= wr_preset(o_drv_op_type);
                        rd_done        <= rd_preset(o_drv_op_type);
                    end
                end
                ST_RUN: begin
                    wdog <= wdog + WDOG_W'(1);
                    if (!i_drv_op_ready) begin
                        busy_seen <= 1'b1;
                    end
                    if (wr_fwd_eop) begin
                        wr_done <= 1'b1;
                    end
                    if (i_drv_read_valid && i_drv_read_eop) begin
                        rd_done <= 1'b1;
                    end
                    if (run_done || wdog_fire) begin
                        grant  <= '0;
                        rr_ptr <= rr_ptr_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Only the owner's write stream reaches the drive; everyone else is silently dropped.
    always_comb begin
        o_drv_write_data  = '0;
        o_drv_write_sop   = 1'b0;
        o_drv_write_eop   = 1'b0;
        o_drv_write_valid = 1'b0;
        if (state != ST_IDLE) begin
            o_drv_write_data  = i_req_write_data[int'(grant_idx)*DATA_W +: DATA_W];
            o_drv_write_sop   = i_req_write_sop[grant_idx];
            o_drv_write_eop   = i_req_write_eop[grant_idx];
            o_drv_write_valid = i_req_write_valid[grant_idx];
        end
    end

    assign wr_fwd_eop = o_drv_write_valid && o_drv_write_eop;

    assign o_req_read_data  = i_drv_read_data;
    assign o_req_read_sop   = i_drv_read_sop;
    assign o_req_read_eop   = i_drv_read_eop;
    assign o_req_read_valid = {P_REQ_NUM{i_drv_read_valid}} & grant;

endmodule

// File: tb/tb_flash_op_arbiter.sv
// Directed self-checking bench for flash_op_arbiter with two requesters and a short watchdog.
module tb_flash_op_arbiter;
    import flash_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic [TYPE_W*N-1:0]    i_req_op_type;
    logic [ADDR_W*N-1:0]    i_req_op_addr;
    logic [NUM_W*N-1:0]     i_req_op_num;
    logic [N-1:0]           i_req_op_valid;
    logic [N-1:0]           o_req_op_ready;
    logic [DATA_W*N-1:0]    i_req_write_data;
    logic [N-1:0]           i_req_write_sop;
    logic [N-1:0]           i_req_write_eop;
    logic [N-1:0]           i_req_write_valid;
    logic [DATA_W-1:0]      o_req_read_data;
    logic                   o_req_read_sop;
    logic                   o_req_read_eop;
    logic [N-1:0]           o_req_read_valid;
    logic [N-1:0]           o_req_timeout;
    logic [TYPE_W-1:0]      o_drv_op_type;
    logic [ADDR_W-1:0]      o_drv_op_addr;
    logic [NUM_W-1:0]       o_drv_op_num;
    logic                   o_drv_op_valid;
    logic                   i_drv_op_ready;
    logic [DATA_W-1:0]      o_drv_write_data;
    logic                   o_drv_write_sop;
    logic                   o_drv_write_eop;
    logic                   o_drv_write_valid;
    logic [DATA_W-1:0]      i_drv_read_data;
    logic                   i_drv_read_sop;
    logic                   i_drv_read_eop;
    logic                   i_drv_read_valid;

    int total;
    int bad;
    int cnt [N];
    int g;
    logic [N-1:0]      exp_ack;
    logic [ADDR_W-1:0] exp_addr;

    flash_op_arbiter #(
        .P_REQ_NUM (N),
        .P_TIMEOUT (TMO)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_req_op_type     (i_req_op_type),
        .i_req_op_addr     (i_req_op_addr),
        .i_req_op_num      (i_req_op_num),
        .i_req_op_valid    (i_req_op_valid),
        .o_req_op_ready    (o_req_op_ready),
        .i_req_write_data  (i_req_write_data),
        .i_req_write_sop   (i_req_write_sop),
        .i_req_write_eop   (i_req_write_eop),
        .i_req_write_valid (i_req_write_valid),
        .o_req_read_data   (o_req_read_data),
        .o_req_read_sop    (o_req_read_sop),
        .o_req_read_eop    (o_req_read_eop),
        .o_req_read_valid  (o_req_read_valid),
        .o_req_timeout     (o_req_timeout),
        .o_drv_op_type     (o_drv_op_type),
        .o_drv_op_addr     (o_drv_op_addr),
        .o_drv_op_num      (o_drv_op_num),
        .o_drv_op_valid    (o_drv_op_valid),
        .i_drv_op_ready    (i_drv_op_ready),
        .o_drv_write_data  (o_drv_write_data),
        .o_drv_write_sop   (o_drv_write_sop),
        .o_drv_write_eop   (o_drv_write_eop),
        .o_drv_write_valid (o_drv_write_valid),
        .i_drv_read_data   (i_drv_read_data),
        .i_drv_read_sop    (i_drv_read_sop),
        .i_drv_read_eop    (i_drv_read_eop),
        .i_drv_read_valid  (i_drv_read_valid)
    );

    initial forever #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [TYPE_W-1:0] t, input logic [ADDR_W-1:0] a,
                                 input logic [NUM_W-1:0] n, input logic v);
        i_req_op_type[k*TYPE_W +: TYPE_W] = t;
        i_req_op_addr[k*ADDR_W +: ADDR_W] = a;
        i_req_op_num[k*NUM_W +: NUM_W]    = n;
        i_req_op_valid[k]                 = v;
    endtask

    task automatic writeBeat(input int k, input logic [DATA_W-1:0] d, input logic s, input logic e, input logic v);
        i_req_write_data[k*DATA_W +: DATA_W] = d;
        i_req_write_sop[k]                   = s;
        i_req_write_eop[k]                   = e;
        i_req_write_valid[k]                 = v;
    endtask

    task automatic readBeat(input logic [DATA_W-1:0] d, input logic s, input logic e, input logic v);
        i_drv_read_data  = d;
        i_drv_read_sop   = s;
        i_drv_read_eop   = e;
        i_drv_read_valid = v;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst = 1'b1;
        i_req_op_type = '0;
        i_req_op_addr = '0;
        i_req_op_num  = '0;
        i_req_op_valid = '0;
        i_req_write_data = '0;
        i_req_write_sop  = '0;
        i_req_write_eop  = '0;
        i_req_write_valid = '0;
        i_drv_op_ready = 1'b1;
        readBeat(8'h00, 1'b0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_op_valid", 32'(o_drv_op_valid), 32'd0);
        checkOutput("rst_op_addr", 32'(o_drv_op_addr), 32'd0);
        checkOutput("rst_op_ready", 32'(o_req_op_ready), 32'd0);
        checkOutput("rst_timeout", 32'(o_req_timeout), 32'd0);
        checkOutput("rst_wr_valid", 32'(o_drv_write_valid), 32'd0);
        checkOutput("rst_rd_valid", 32'(o_req_read_valid), 32'd0);
        i_rst = 1'b0;
        tick();

        // Single read by requester 0
        applyStimulus(0, OP_READ, 24'h000100, 9'd4, 1'b1);
        #1;
        checkOutput("rd_latency", 32'(o_drv_op_valid), 32'd0);
        tick();
        checkOutput("rd_issue_valid", 32'(o_drv_op_valid), 32'd1);
        checkOutput("rd_issue_type", 32'(o_drv_op_type), 32'd2);
        checkOutput("rd_issue_addr", 32'(o_drv_op_addr), 32'h100);
        checkOutput("rd_issue_num", 32'(o_drv_op_num), 32'd4);
        checkOutput("rd_ack", 32'(o_req_op_ready), 32'b01);
        tick();
        applyStimulus(0, OP_READ, 24'h000100, 9'd4, 1'b0);
        i_drv_op_ready = 1'b0;
        #1;
        checkOutput("rd_ack_once", 32'(o_req_op_ready), 32'd0);
        checkOutput("rd_op_valid_low", 32'(o_drv_op_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            readBeat(8'(8'h10 + i), (i == 0), (i == 3), 1'b1);
            #1;
            checkOutput("rd_valid", 32'(o_req_read_valid), 32'b01);
            checkOutput("rd_data", 32'(o_req_read_data), 32'(8'h10 + i));
            tick();
        end
        readBeat(8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("rd_hold_busy", 32'(o_req_read_valid), 32'b01);
        tick();
        i_drv_op_ready = 1'b1;
        #1;
        checkOutput("rd_hold_ready", 32'(o_req_read_valid), 32'b01);
        tick();
        checkOutput("rd_released", 32'(o_req_read_valid), 32'b00);
        readBeat(8'h00, 1'b0, 1'b0, 1'b0);

        // Write by requester 1 while requester 0 toggles its write stream
        applyStimulus(1, OP_WRITE, 24'h000200, 9'd3, 1'b1);
        writeBeat(0, 8'h11, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("wr_idle_drop", 32'(o_drv_write_valid), 32'd0);
        tick();
        writeBeat(0, 8'h22, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("wr_issue_type", 32'(o_drv_op_type), 32'd1);
        checkOutput("wr_ack", 32'(o_req_op_ready), 32'b10);
        checkOutput("wr_issue_nodata", 32'(o_drv_write_valid), 32'd0);
        tick();
        applyStimulus(1, OP_WRITE, 24'h000200, 9'd3, 1'b0);
        i_drv_op_ready = 1'b0;
        writeBeat(1, 8'hA5, 1'b1, 1'b0, 1'b1);
        writeBeat(0, 8'h33, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("wr_b0_valid", 32'(o_drv_write_valid), 32'd1);
        checkOutput("wr_b0_data", 32'(o_drv_write_data), 32'hA5);
        checkOutput("wr_b0_sop", 32'(o_drv_write_sop), 32'd1);
        checkOutput("wr_b0_eop", 32'(o_drv_write_eop), 32'd0);
        tick();
        i_drv_op_ready = 1'b1;
        writeBeat(1, 8'h5A, 1'b0, 1'b0, 1'b1);
        writeBeat(0, 8'h44, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("wr_b1_data", 32'(o_drv_write_data), 32'h5A);
        tick();
        writeBeat(1, 8'h00, 1'b0, 1'b0, 1'b0);
        writeBeat(0, 8'h77, 1'b0, 1'b1, 1'b1);
        readBeat(8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("wr_gap_valid", 32'(o_drv_write_valid), 32'd0);
        tick();
        writeBeat(1, 8'hFF, 1'b0, 1'b1, 1'b1);
        writeBeat(0, 8'h88, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("wr_wait_eop", 32'(o_req_read_valid), 32'b10);
        checkOutput("wr_b2_data", 32'(o_drv_write_data), 32'hFF);
        checkOutput("wr_b2_eop", 32'(o_drv_write_eop), 32'd1);
        tick();
        writeBeat(1, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("wr_hold_after_eop", 32'(o_req_read_valid), 32'b10);
        tick();
        checkOutput("wr_released", 32'(o_req_read_valid), 32'b00);
        readBeat(8'h00, 1'b0, 1'b0, 1'b0);
        writeBeat(1, 8'h99, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("wr_idle_valid", 32'(o_drv_write_valid), 32'd0);
        writeBeat(1, 8'h00, 1'b0, 1'b0, 1'b0);

        // Contention: both requesters hold three erases each
        cnt[0] = 0;
        cnt[1] = 0;
        applyStimulus(0, OP_ERASE, 24'h001000, 9'd1, 1'b1);
        applyStimulus(1, OP_ERASE, 24'h002000, 9'd1, 1'b1);
        for (int op = 0; op < 6; op++) begin
            g        = op % 2;
            exp_ack  = (g == 0) ? 2'b01 : 2'b10;
            exp_addr = (g == 0) ? 24'h001000 : 24'h002000;
            tick();
            checkOutput("cn_ack", 32'(o_req_op_ready), 32'(exp_ack));
            checkOutput("cn_addr", 32'(o_drv_op_addr), 32'(exp_addr));
            tick();
            cnt[g]++;
            if (cnt[g] == 3) begin
                i_req_op_valid[g] = 1'b0;
            end
            i_drv_op_ready = 1'b0;
            #1;
            checkOutput("cn_ack_once", 32'(o_req_op_ready), 32'd0);
            tick();
            i_drv_op_ready = 1'b1;
            tick();
        end

        // Erase by requester 0 with requester 1 waiting
        applyStimulus(0, OP_ERASE, 24'h003000, 9'd1, 1'b1);
        tick();
        checkOutput("er_type", 32'(o_drv_op_type), 32'd0);
        checkOutput("er_ack", 32'(o_req_op_ready), 32'b01);
        tick();
        i_req_op_valid[0] = 1'b0;
        i_drv_op_ready = 1'b0;
        applyStimulus(1, OP_READ, 24'h004000, 9'd1, 1'b1);
        #1;
        checkOutput("er_run_valid", 32'(o_drv_op_valid), 32'd0);
        tick();
        i_drv_op_ready = 1'b1;
        tick();
        checkOutput("er_gap", 32'(o_drv_op_valid), 32'd0);
        tick();
        checkOutput("er_next_valid", 32'(o_drv_op_valid), 32'd1);
        checkOutput("er_next_addr", 32'(o_drv_op_addr), 32'h004000);
        checkOutput("er_next_ack", 32'(o_req_op_ready), 32'b10);

        // Watchdog: drive stays busy for requester 1's read
        tick();
        i_req_op_valid[1] = 1'b0;
        i_drv_op_ready = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            #1;
            checkOutput("to_quiet", 32'(o_req_timeout), 32'd0);
            tick();
        end
        #1;
        checkOutput("to_pulse", 32'(o_req_timeout), 32'b10);
        tick();
        i_drv_op_ready = 1'b1;
        readBeat(8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("to_pulse_once", 32'(o_req_timeout), 32'd0);
        checkOutput("to_released", 32'(o_req_read_valid), 32'b00);
        readBeat(8'h00, 1'b0, 1'b0, 1'b0);

        // Pointer advanced past requester 1, then reset in the middle of a read
        applyStimulus(0, OP_READ, 24'h005000, 9'd8, 1'b1);
        applyStimulus(1, OP_WRITE, 24'h006000, 9'd8, 1'b1);
        tick();
        checkOutput("to_ptr_advanced", 32'(o_req_op_ready), 32'b01);
        checkOutput("rs_addr", 32'(o_drv_op_addr), 32'h005000);
        tick();
        i_req_op_valid = '0;
        i_drv_op_ready = 1'b0;
        readBeat(8'hC3, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("rs_run_grant", 32'(o_req_read_valid), 32'b01);
        tick();
        tick();
        #3;
        i_rst = 1'b1;
        #1;
        checkOutput("rs_async_grant", 32'(o_req_read_valid), 32'b00);
        tick();
        checkOutput("rs_op_addr", 32'(o_drv_op_addr), 32'd0);
        checkOutput("rs_op_valid", 32'(o_drv_op_valid), 32'd0);
        checkOutput("rs_timeout", 32'(o_req_timeout), 32'd0);
        checkOutput("rs_ack", 32'(o_req_op_ready), 32'd0);
        readBeat(8'h00, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b0;
        i_drv_op_ready = 1'b1;
        tick();

        // Reserved op type completes on busy then ready
        applyStimulus(1, 2'd3, 24'h007000, 9'd1, 1'b1);
        #1;
        checkOutput("r3_idle_valid", 32'(o_drv_op_valid), 32'd0);
        tick();
        checkOutput("r3_valid", 32'(o_drv_op_valid), 32'd1);
        checkOutput("r3_type", 32'(o_drv_op_type), 32'd3);
        checkOutput("r3_ack", 32'(o_req_op_ready), 32'b10);
        tick();
        i_req_op_valid[1] = 1'b0;
        i_drv_op_ready = 1'b0;
        readBeat(8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("r3_grant", 32'(o_req_read_valid), 32'b10);
        tick();
        i_drv_op_ready = 1'b1;
        tick();
        checkOutput("r3_released", 32'(o_req_read_valid), 32'b00);
        checkOutput("r3_no_timeout", 32'(o_req_timeout), 32'd0);
        readBeat(8'h00, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
